// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter for a shared XOR/OR/AND/pass unit; result lands in a one-entry slot the cycle after accept.
// READY drops while the slot is full and not draining; `LOGIC_ARB_ROUND_ROBIN_EN selects round-robin, else fixed R0 priority.
module logic_unit_arbiter #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_r0_valid,
  output logic         o_r0_ready,
  input  logic [1:0]   i_r0_op,
  input  logic [N-1:0] i_r0_in1,
  input  logic [N-1:0] i_r0_in2,
  input  logic         i_r1_valid,
  output logic         o_r1_ready,
  input  logic [1:0]   i_r1_op,
  input  logic [N-1:0] i_r1_in1,
  input  logic [N-1:0] i_r1_in2,
  output logic         o_res_valid,
  input  logic         i_res_ready,
  output logic [N-1:0] o_res,
  output logic         o_res_id
);

  typedef struct packed {
    logic         id;
    logic [N-1:0] res;
  } slot_t;

  logic         r_valid;
  slot_t        r_slot;
  logic         w_pri;
  logic         w_free;
  logic         w_grant;
  logic         w_accept;
  logic [1:0]   w_op;
  logic [N-1:0] w_in1;
  logic [N-1:0] w_in2;
  logic [N-1:0] w_result;

  function automatic logic [N-1:0] f_logic(input logic [1:0] op,
                                           input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    logic [N-1:0] y;
    case (op)
      2'b00:   y = a ^ b;
      2'b01:   y = a | b;
      2'b10:   y = a & b;
      default: y = a;
    endcase
    return y;
  endfunction

`ifdef LOGIC_ARB_ROUND_ROBIN_EN
  logic r_pri;

  // Pointer goes to whichever requester did not just win.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pri <= 1'b0;
    end else if (w_accept) begin
      r_pri <= ~w_grant;
    end
  end

  assign w_pri = r_pri;
`else
  assign w_pri = 1'b0;
`endif

  always_comb begin
    w_free   = !r_valid || i_res_ready;
    w_grant  = (i_r0_valid && i_r1_valid) ? w_pri : i_r1_valid;
    w_accept = w_free && (i_r0_valid || i_r1_valid) && !i_rst;
    w_op     = w_grant ? i_r1_op  : i_r0_op;
    w_in1    = w_grant ? i_r1_in1 : i_r0_in1;
    w_in2    = w_grant ? i_r1_in2 : i_r0_in2;
    w_result = f_logic(w_op, w_in1, w_in2);
  end

  assign o_r0_ready = w_accept && !w_grant;
  assign o_r1_ready = w_accept &&  w_grant;

  // A drain with no accept only clears valid; the stale payload stays visible.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_slot  <= '0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_slot.id   <= w_grant;
      r_slot.res  <= w_result;
    end else if (i_res_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_res_valid = r_valid;
  assign o_res       = r_slot.res;
  assign o_res_id    = r_slot.id;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter; expectations follow the build's LOGIC_ARB_ROUND_ROBIN_EN setting.
module tb_logic_unit_arbiter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         r0_valid, r1_valid;
  logic         r0_ready, r1_ready;
  logic [1:0]   r0_op, r1_op;
  logic [N-1:0] r0_in1, r0_in2, r1_in1, r1_in2;
  logic         res_valid, res_ready;
  logic [N-1:0] res;
  logic         res_id;

  int checks = 0;
  int errors = 0;

  logic_unit_arbiter #(.N(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_r0_valid  (r0_valid),
    .o_r0_ready  (r0_ready),
    .i_r0_op     (r0_op),
    .i_r0_in1    (r0_in1),
    .i_r0_in2    (r0_in2),
    .i_r1_valid  (r1_valid),
    .o_r1_ready  (r1_ready),
    .i_r1_op     (r1_op),
    .i_r1_in1    (r1_in1),
    .i_r1_in2    (r1_in2),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res       (res),
    .o_res_id    (res_id)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    r0_valid = 1'b1; r1_valid = 1'b1; res_ready = 1'b1;
    r0_op = 2'b00; r0_in1 = '0; r0_in2 = '0;
    r1_op = 2'b00; r1_in1 = '0; r1_in2 = '0;
    #2;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res got=%h exp=00000000", res); end
    checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL reset_id got=%b exp=0", res_id); end
    step();
    checks++; if ({r0_ready, r1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {r0_ready, r1_ready}); end
    r0_valid = 1'b0; r1_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    r0_valid = 1'b1; r0_op = 2'b00; r0_in1 = 32'hF0F0F0F0; r0_in2 = 32'hFF00FF00;
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if ({r0_ready, r1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got=%b exp=10", {r0_ready, r1_ready}); end
    step();
    r0_valid = 1'b0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", res_valid); end
    checks++; if (res !== 32'h0FF00FF0) begin errors++; $display("FAIL single_res got=%h exp=0ff00ff0", res); end
    checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL single_id got=%b exp=0", res_id); end
    step();
  endtask

  task automatic test_opcode_sweep();
    logic [N-1:0] exp_tab [4];
    exp_tab[0] = 32'hAAAAAAAA; exp_tab[1] = 32'hAFAFAFAF;
    exp_tab[2] = 32'h05050505; exp_tab[3] = 32'hA5A5A5A5;
    r1_in1 = 32'hA5A5A5A5; r1_in2 = 32'h0F0F0F0F;
    for (int k = 0; k < 4; k++) begin
      r1_valid = 1'b1; r1_op = 2'(k);
      @(negedge clk);
      checks++; if (r1_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready op=%0d got=%b exp=1", k, r1_ready); end
      step();
      r1_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res !== exp_tab[k] || res_id !== 1'b1) begin
        errors++;
        $display("FAIL sweep_res op=%0d got=%b/%h/%b exp=1/%h/1", k, res_valid, res, res_id, exp_tab[k]);
      end
      step();
    end
  endtask

  task automatic test_both_valid();
    logic [3:0] exp_ids;
    logic       r1_seen;
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
    exp_ids = 4'b1010;
`else
    exp_ids = 4'b0000;
`endif
    r1_seen = 1'b0;
    r0_op = 2'b00; r0_in1 = 32'h1;  r0_in2 = 32'h3;
    r1_op = 2'b01; r1_in1 = 32'h10; r1_in2 = 32'h01;
    r0_valid = 1'b1; r1_valid = 1'b1; res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (r1_ready === 1'b1) r1_seen = 1'b1;
      checks++;
      if ((r0_ready & r1_ready) !== 1'b0 || (r0_ready | r1_ready) !== 1'b1) begin
        errors++; $display("FAIL both_ready_onehot cyc=%0d got=%b exp=one-hot", k, {r0_ready, r1_ready});
      end
      step();
      if (k == 3) begin r0_valid = 1'b0; r1_valid = 1'b0; end
      @(negedge clk);
      checks++;
      if (res_id !== exp_ids[k] || res !== (exp_ids[k] ? 32'h11 : 32'h2) || res_valid !== 1'b1) begin
        errors++;
        $display("FAIL both_seq cyc=%0d got=%b/%h exp=%b/%h", k, res_id, res, exp_ids[k], exp_ids[k] ? 32'h11 : 32'h2);
      end
    end
`ifndef LOGIC_ARB_ROUND_ROBIN_EN
    checks++; if (r1_seen !== 1'b0) begin errors++; $display("FAIL both_r1_starve got=%b exp=0", r1_seen); end
`endif
  endtask

  task automatic test_drain_only();
    logic [N-1:0] stale;
    logic         stale_id;
    stale = res; stale_id = res_id;
    res_ready = 1'b1;
    step();
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", res_valid); end
    checks++;
    if (res !== stale || res_id !== stale_id) begin
      errors++; $display("FAIL drain_hold got=%h/%b exp=%h/%b", res, res_id, stale, stale_id);
    end
    step();
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    r0_valid = 1'b1; r0_op = 2'b10; r0_in1 = 32'hFFFF0000; r0_in2 = 32'h12345678;
    @(negedge clk);
    checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL bp_fill_ready got=%b exp=1", r0_ready); end
    step();
    r0_op = 2'b11; r0_in1 = 32'hCAFEBABE;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (r0_ready !== 1'b0 || res_valid !== 1'b1 || res !== 32'h12340000) begin
        errors++; $display("FAIL bp_stall cyc=%0d got=%b/%b/%h exp=0/1/12340000", k, r0_ready, res_valid, res);
      end
      step();
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", r0_ready); end
    step();
    r0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res !== 32'hCAFEBABE || res_id !== 1'b0) begin
      errors++; $display("FAIL bp_overlap got=%b/%h/%b exp=1/cafebabe/0", res_valid, res, res_id);
    end
    step();
    step();
  endtask

  task automatic test_reset_mid_stall();
    res_ready = 1'b0;
    r0_valid = 1'b1; r0_op = 2'b01; r0_in1 = 32'h00F0_0000; r0_in2 = 32'h0000_000F;
    step();
    r0_valid = 1'b0;
    @(negedge clk);
    checks++; if (res !== 32'h00F0000F) begin errors++; $display("FAIL mid_fill got=%h exp=00f0000f", res); end
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_op = 2'b11; r0_in1 = 32'h0BADF00D;
    r1_op = 2'b11; r1_in1 = 32'h0D15EA5E;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0 || res !== 32'h0 || res_id !== 1'b0 || {r0_ready, r1_ready} !== 2'b00) begin
      errors++; $display("FAIL mid_reset got=%b/%h/%b/%b exp=0/00000000/0/00", res_valid, res, res_id, {r0_ready, r1_ready});
    end
    step();
    rst = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if ({r0_ready, r1_ready} !== 2'b10) begin errors++; $display("FAIL mid_first_tie got=%b exp=10", {r0_ready, r1_ready}); end
    step();
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res !== 32'h0BADF00D || res_id !== 1'b0) begin
      errors++; $display("FAIL mid_first_res got=%b/%h/%b exp=1/0badf00d/0", res_valid, res, res_id);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_opcode_sweep();
    test_both_valid();
    test_drain_only();
    test_backpressure();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
